quad_decoder: RTL

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder_pkg.sv | 46 ++++
 rtl/quad_debounce.sv | 78 +++++++
 rtl/quad_decoder.sv | 85 ++++++++
 3 files changed

// File: rtl/quad_decoder_pkg.sv
// Shared quadrature constants and transition classification for the decoder and
// the quadrature state generator.
package quad_pkg;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  localparam logic DirFwd = 1'b1;
  localparam logic DirRev = 1'b0;

  typedef enum logic [1:0] {
    MoveNone,
    MoveFwd,
    MoveRev,
    MoveIllegal
  } move_e;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    logic [1:0] n;
    unique case (s)
      Q00:     n = Q01;
      Q01:     n = Q11;
      Q11:     n = Q10;
      default: n = Q00;
    endcase
    return n;
  endfunction

  function automatic move_e classify(input logic [1:0] old_s, input logic [1:0] new_s);
    move_e m;
    if (new_s == old_s) begin
      m = MoveNone;
    end else if (new_s == fwd_next(old_s)) begin
      m = MoveFwd;
    end else if (old_s == fwd_next(new_s)) begin
      m = MoveRev;
    end else begin
      m = MoveIllegal;
    end
    return m;
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// Two-flop synchronizer plus strobe-driven run-length filter for the {A,B} pair.
// chg_o pulses with the filtered update once primed; old_o holds the value it replaced.
module quad_debounce
  import quad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SAMPLES = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sample_en_i,
  input  logic [1:0] raw_i,
  output logic [1:0] filt_o,
  output logic [1:0] old_o,
  output logic       chg_o
);

  localparam logic [3:0] CntAccept = 4'(DEBOUNCE_SAMPLES);
  localparam logic [3:0] CntMax    = 4'hF;

  logic [1:0] sync1_q, sync2_q;
  logic [1:0] prev_q, prev_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] filt_q, filt_d;
  logic [1:0] old_q, old_d;
  logic       primed_q, primed_d;
  logic       chg_q, chg_d;

  always_comb begin
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    filt_d   = filt_q;
    old_d    = old_q;
    primed_d = primed_q;
    chg_d    = 1'b0;
    if (sample_en_i) begin
      prev_d = sync2_q;
      if (sync2_q == prev_q) begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
      end
      // The first accepted value only primes the filter; no change is reported.
      if (cnt_d >= CntAccept && (!primed_q || sync2_q != filt_q)) begin
        filt_d   = sync2_q;
        old_d    = filt_q;
        primed_d = 1'b1;
        chg_d    = primed_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= Q00;
      sync2_q  <= Q00;
      prev_q   <= Q00;
      cnt_q    <= 4'd0;
      filt_q   <= Q00;
      old_q    <= Q00;
      primed_q <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      filt_q   <= filt_d;
      old_q    <= old_d;
      primed_q <= primed_d;
      chg_q    <= chg_d;
    end
  end

  assign filt_o = filt_q;
  assign old_o  = old_q;
  assign chg_o  = chg_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: debounced {A,B} transitions drive a wrapping signed position
// counter, a one-clk step strobe, the last direction and a sticky illegal-move flag.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH      = 16,
  parameter int unsigned DEBOUNCE_SAMPLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_en,
  input  logic [1:0]             quad_in,
  input  logic                   err_clr,
  output logic [COUNT_WIDTH-1:0] position,
  output logic                   step_valid,
  output logic                   dir,
  output logic                   err
);

  localparam logic [COUNT_WIDTH-1:0] PosOne = COUNT_WIDTH'(1);

  logic [1:0] filt, filt_old;
  logic       filt_chg;
  move_e      move;

  logic [COUNT_WIDTH-1:0] position_q, position_d;
  logic                   step_valid_q, step_valid_d;
  logic                   dir_q, dir_d;
  logic                   err_q, err_d;

  quad_debounce #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
  ) u_debounce (
    .clk_i      (clk),
    .rst_i      (rst),
    .sample_en_i(sample_en),
    .raw_i      (quad_in),
    .filt_o     (filt),
    .old_o      (filt_old),
    .chg_o      (filt_chg)
  );

  always_comb begin
    move         = filt_chg ? classify(filt_old, filt) : MoveNone;
    position_d   = position_q;
    step_valid_d = 1'b0;
    dir_d        = dir_q;
    err_d        = err_clr ? 1'b0 : err_q;
    unique case (move)
      MoveFwd: begin
        position_d   = position_q + PosOne;
        dir_d        = DirFwd;
        step_valid_d = 1'b1;
      end
      MoveRev: begin
        position_d   = position_q - PosOne;
        dir_d        = DirRev;
        step_valid_d = 1'b1;
      end
      // A new illegal move wins over a coincident clear.
      MoveIllegal: err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      position_q   <= '0;
      step_valid_q <= 1'b0;
      dir_q        <= DirFwd;
      err_q        <= 1'b0;
    end else begin
      position_q   <= position_d;
      step_valid_q <= step_valid_d;
      dir_q        <= dir_d;
      err_q        <= err_d;
    end
  end

  assign position   = position_q;
  assign step_valid = step_valid_q;
  assign dir        = dir_q;
  assign err        = err_q;

endmodule
